async_fifo_wr_arbiter: RTL and testbench
========================================

// Module: async_fifo_wr_arbiter
// PURPOSE
//  Round-robin write-port arbiter in the wr_clk domain of async_fifo. Shares the FIFO
//  write port (wr_en/data_in/full) among NUM_REQ requesters, each with valid/ready/last.
//  A grant is held for a burst: until a beat with last is accepted or MAX_BURST beats are
//  accepted. Bursts from different requesters never interleave in the FIFO.
// PARAMETERS
//  NUM_REQ     4   number of requesters (>=2)
//  DATA_WIDTH  16  beat width, equal to the FIFO's DATA_WIDTH
//  MAX_BURST   8   max beats per grant (>=1); forces release even without last
// PORTS
//  wr_clk      in   1                    write-domain clock
//  wr_rst      in   1                    reset, asynchronous, active-high
//  req_valid   in   NUM_REQ              per-requester beat valid
//  req_data    in   NUM_REQ*DATA_WIDTH   per-requester beat; requester i in [i*DW +: DW]
//  req_last    in   NUM_REQ              beat is last of packet; qualified by valid
//  req_ready   out  NUM_REQ              beat accepted this cycle (valid&ready = transfer)
//  fifo_full   in   1                    FIFO full flag
//  fifo_wr_en  out  1                    to FIFO wr_en
//  fifo_data   out  DATA_WIDTH           to FIFO data_in
//  grant       out  NUM_REQ              one-hot current owner; 0 when idle
//  busy        out  1                    high in BURST state
// BEHAVIOUR
//  Reset (async, any time): state=IDLE, grant=0, beat_cnt=0, last_owner=NUM_REQ-1
//   (so requester 0 has top priority first); req_ready=0, fifo_wr_en=0, fifo_data=0, busy=0.
//   A burst cut by reset is abandoned; nothing more is written for it.
//  FSM IDLE: if any req_valid, pick the first valid index searching upward (cyclically)
//   from last_owner+1; register grant, beat_cnt=0, go to BURST. No valid: stay.
//   Arbitration latency is 1 cycle: no transfer happens in IDLE.
//  FSM BURST (owner g): combinational fire = req_valid[g] & ~fifo_full;
//   req_ready[g]=fire, other req_ready=0; fifo_wr_en=fire; fifo_data=req_data[g]
//   (fifo_data=0 when grant=0). On fire: beat_cnt++.
//   Release when fire & (req_last[g] | beat_cnt==MAX_BURST-1): last_owner=g, grant=0,
//   beat_cnt=0, go to IDLE. One idle bubble cycle between bursts is required.
//  Owner dropping valid mid-burst: grant held, no writes, no timeout.
//  fifo_full high: no fire, grant and beat_cnt held; resumes the cycle full clears.
//  req_ready never asserts while fifo_full=1 or for a non-owner.
//  beat_cnt width $clog2(MAX_BURST+1); never exceeds MAX_BURST-1 when held.
//  MAX_BURST=1: every accepted beat releases the grant.
//  Requests arriving while another owner is in BURST wait; no preemption.
//  Fairness: a continuously valid requester is granted within NUM_REQ-1 other bursts.
//  last with valid low is ignored. fifo_wr_en is never high in IDLE.
//  Requesters must hold data/last stable while valid & ~ready.
// TESTING
//  1 Reset: wr_rst pulse mid-burst -> grant=0, fifo_wr_en=0, req_ready=0 same cycle;
//    after release req 0 and 2 valid -> req 0 granted first.
//  2 Round-robin: all 4 valid, 1-beat packets (last=1) -> grant order 0,1,2,3,0, one
//    write per 2 cycles, FIFO contents in that order.
//  3 Burst cap: req 1 sends 20 beats, no last, MAX_BURST=8 -> 8 beats, IDLE,
//    regrant (if alone) 8, then 4; data 0x0100..0x0113 in order, no gaps/duplicates.
//  4 Full backpressure: fifo_full=1 for 5 cycles at beat 3 of 6 -> fifo_wr_en=0,
//    req_ready=0, beat_cnt=3 held; beats 3..5 written after full drops.
//  5 Valid gap: owner 2 drops valid 3 cycles mid-packet while req 3 valid -> grant stays
//    2; req 3 granted only after 2's last beat.
//  6 Random: 4 random valid/last sources + random fifo_full -> per-requester packets
//    contiguous and in order in FIFO, no interleave, no writes while full.

Source files
------------

// File: rtl/async_fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing the async FIFO write port among
// NUM_REQ valid/ready/last requesters in the wr_clk domain.
module async_fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 16,
    parameter int MAX_BURST  = 8
) (
    input  logic                          wr_clk,
    input  logic                          wr_rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_wr_en,
    output logic [DATA_WIDTH-1:0]         fifo_data,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          busy
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic {
        IDLE,
        BURST
    } state_t;

    state_t                  state;
    state_t                  state_n;
    logic [NUM_REQ-1:0]      grant_n;
    logic [IW-1:0]           last_owner;
    logic [IW-1:0]           last_owner_n;
    logic [CW-1:0]           beat_cnt;
    logic [CW-1:0]           beat_cnt_n;

    logic [IW-1:0]           owner_idx;
    logic                    owner_valid;
    logic                    owner_last;
    logic [DATA_WIDTH-1:0]   owner_data;
    logic                    fire;
    logic                    release_burst;

    logic                    hi_found;
    logic [IW-1:0]           hi_pick;
    logic [IW-1:0]           lo_pick;
    logic [IW-1:0]           pick;

    // Owner mux keyed on the one-hot grant; all zero while idle.
    always_comb begin
        owner_idx   = '0;
        owner_valid = 1'b0;
        owner_last  = 1'b0;
        owner_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                owner_idx   = IW'(i);
                owner_valid = req_valid[i];
                owner_last  = req_last[i];
                owner_data  = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Lowest valid index above last_owner wins, else lowest at or below it.
    always_comb begin
        hi_found = 1'b0;
        hi_pick  = '0;
        lo_pick  = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                if (IW'(i) > last_owner) begin
                    hi_found = 1'b1;
                    hi_pick  = IW'(i);
                end else begin
                    lo_pick = IW'(i);
                end
            end
        end
        pick = hi_found ? hi_pick : lo_pick;
    end

    assign fire          = (state == BURST) & owner_valid & ~fifo_full;
    assign release_burst = fire &
                           (owner_last | (beat_cnt == CW'(MAX_BURST - 1)));

    assign req_ready  = fire ? grant : '0;
    assign fifo_wr_en = fire;
    assign fifo_data  = owner_data;
    assign busy       = (state == BURST);

    always_comb begin
        state_n      = state;
        grant_n      = grant;
        beat_cnt_n   = beat_cnt;
        last_owner_n = last_owner;
        unique case (state)
            IDLE: begin
                if (|req_valid) begin
                    state_n       = BURST;
                    grant_n       = '0;
                    grant_n[pick] = 1'b1;
                    beat_cnt_n    = '0;
                end
            end
            BURST: begin
                if (release_burst) begin
                    state_n      = IDLE;
                    grant_n      = '0;
                    beat_cnt_n   = '0;
                    last_owner_n = owner_idx;
                end else if (fire) begin
                    beat_cnt_n = beat_cnt + CW'(1);
                end
            end
            default: begin
                state_n = IDLE;
                grant_n = '0;
            end
        endcase
    end

    always_ff @(posedge wr_clk or posedge wr_rst) begin
        if (wr_rst) begin
            state      <= IDLE;
            grant      <= '0;
            beat_cnt   <= '0;
            last_owner <= IW'(NUM_REQ - 1);
        end else begin
            state      <= state_n;
            grant      <= grant_n;
            beat_cnt   <= beat_cnt_n;
            last_owner <= last_owner_n;
        end
    end

endmodule

// File: tb/tb_async_fifo_wr_arbiter.sv
// Randomized and directed bench for async_fifo_wr_arbiter against a
// cycle-level reference model of the round-robin burst rules.
module tb_async_fifo_wr_arbiter;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int MB = 8;

    logic            wr_clk = 1'b0;
    logic            wr_rst;
    logic [N-1:0]    req_valid;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_last;
    logic [N-1:0]    req_ready;
    logic            fifo_full;
    logic            fifo_wr_en;
    logic [DW-1:0]   fifo_data;
    logic [N-1:0]    grant;
    logic            busy;

    async_fifo_wr_arbiter #(
        .NUM_REQ   (N),
        .DATA_WIDTH(DW),
        .MAX_BURST (MB)
    ) dut (
        .wr_clk    (wr_clk),
        .wr_rst    (wr_rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .fifo_full (fifo_full),
        .fifo_wr_en(fifo_wr_en),
        .fifo_data (fifo_data),
        .grant     (grant),
        .busy      (busy)
    );

    always #5 wr_clk = ~wr_clk;

    typedef struct packed {
        logic          l;
        logic [DW-1:0] d;
    } beat_t;

    typedef struct packed {
        int            cyc;
        int            req;
        logic          l;
        logic [DW-1:0] d;
    } wlog_t;

    beat_t         src_q[N][$];
    logic [DW-1:0] exp_q[N][$];
    wlog_t         wlog[$];
    int            sizes[$];

    int            n_checks = 0;
    int            n_fail   = 0;
    int            cyc      = 0;
    int            vprob    = 100;
    logic [N-1:0]  mute;
    logic [N-1:0]  acc;

    int            m_owner;
    int            m_cnt;
    int            m_last;

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    task automatic do_reset();
        wr_rst    = 1'b1;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        fifo_full = 1'b0;
        mute      = '0;
        acc       = '0;
        for (int i = 0; i < N; i++) src_q[i].delete();
        m_owner = -1;
        m_cnt   = 0;
        m_last  = N - 1;
        @(posedge wr_clk);
        #1;
        wr_rst = 1'b0;
        wlog.delete();
    endtask

    // Sources: pop accepted beats, hold unaccepted ones, else random valid.
    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
            if (!(req_valid[i] && !acc[i])) begin
                if (src_q[i].size() > 0 && !mute[i] &&
                    $urandom_range(99) < 32'(vprob)) begin
                    req_valid[i]         = 1'b1;
                    req_data[i*DW +: DW] = src_q[i][0].d;
                    req_last[i]          = src_q[i][0].l;
                end else begin
                    req_valid[i]         = 1'b0;
                    req_data[i*DW +: DW] = DW'($urandom);
                    req_last[i]          = 1'($urandom);
                end
            end
        end
    endtask

    // Compare all outputs to the model at negedge, then advance the model.
    task automatic cycle();
        logic [N-1:0]  eg;
        logic [N-1:0]  er;
        logic [DW-1:0] ed;
        logic          fire;
        wlog_t         w;
        @(negedge wr_clk);
        eg   = '0;
        er   = '0;
        ed   = '0;
        fire = 1'b0;
        if (m_owner >= 0) begin
            eg[m_owner] = 1'b1;
            ed          = req_data[m_owner*DW +: DW];
            fire        = req_valid[m_owner] && !fifo_full;
            if (fire) er[m_owner] = 1'b1;
        end
        check("cycle", {grant, req_ready, fifo_wr_en, busy, fifo_data},
              {eg, er, fire, (m_owner >= 0), ed});
        if (fifo_wr_en) begin
            w.cyc = cyc;
            w.req = -1;
            w.l   = 1'b0;
            w.d   = fifo_data;
            for (int i = 0; i < N; i++) begin
                if (grant[i]) begin
                    w.req = i;
                    w.l   = req_last[i];
                end
            end
            wlog.push_back(w);
        end
        acc = req_valid & req_ready;
        if (m_owner < 0) begin
            for (int k = 1; k <= N; k++) begin
                int j;
                j = (m_last + k) % N;
                if (req_valid[j]) begin
                    m_owner = j;
                    m_cnt   = 0;
                    break;
                end
            end
        end else if (fire) begin
            m_cnt++;
            if (req_last[m_owner] || m_cnt == MB) begin
                m_last  = m_owner;
                m_owner = -1;
                m_cnt   = 0;
            end
        end
        @(posedge wr_clk);
        #1;
        cyc++;
    endtask

    task automatic push_pkt(int r, int len, logic [DW-1:0] base, logic lst);
        beat_t b;
        for (int k = 0; k < len; k++) begin
            b.d = base + DW'(k);
            b.l = lst && (k == len - 1);
            src_q[r].push_back(b);
        end
    endtask

    initial begin
        int fullc;
        int gapc;
        int cur;
        int total;
        int viol;
        int own;
        int bcnt;

        // Reset state and asynchronous reset mid-burst
        do_reset();
        check("rst_grant", grant, 0);
        check("rst_busy", busy, 0);
        check("rst_wr_en", fifo_wr_en, 0);
        check("rst_ready", req_ready, 0);
        check("rst_data", fifo_data, 0);
        push_pkt(0, 6, 16'h0700, 1'b1);
        for (int t = 0; t < 40 && wlog.size() < 3; t++) begin
            drive();
            cycle();
        end
        check("pre_rst_writes", wlog.size(), 3);
        drive();
        check("pre_rst_grant", grant, 4'b0001);
        #2;
        wr_rst = 1'b1;
        #1;
        check("async_rst_grant", grant, 0);
        check("async_rst_wr_en", fifo_wr_en, 0);
        check("async_rst_ready", req_ready, 0);
        do_reset();
        push_pkt(0, 1, 16'h0AAA, 1'b1);
        push_pkt(2, 1, 16'h0BBB, 1'b1);
        for (int t = 0; t < 40 && wlog.size() < 2; t++) begin
            drive();
            cycle();
        end
        check("rst_prio_writes", wlog.size(), 2);
        if (wlog.size() >= 2) begin
            check("rst_prio_first", wlog[0].req, 0);
            check("rst_prio_data", wlog[0].d, 16'h0AAA);
            check("rst_prio_second", wlog[1].req, 2);
        end

        // Round-robin with single-beat packets
        do_reset();
        for (int i = 0; i < N; i++) begin
            push_pkt(i, 1, 16'hA000 + DW'(i * 16), 1'b1);
            push_pkt(i, 1, 16'hA001 + DW'(i * 16), 1'b1);
        end
        for (int t = 0; t < 60 && wlog.size() < 8; t++) begin
            drive();
            cycle();
        end
        check("rr_writes", wlog.size(), 8);
        if (wlog.size() >= 8) begin
            for (int k = 0; k < 8; k++) begin
                check("rr_order", wlog[k].req, k % N);
                check("rr_data", wlog[k].d,
                      16'hA000 + DW'((k % N) * 16 + k / N));
                if (k > 0) check("rr_spacing", wlog[k].cyc - wlog[k-1].cyc, 2);
            end
        end

        // Burst cap: 20 beats without last split 8/8/4
        do_reset();
        push_pkt(1, 20, 16'h0100, 1'b0);
        for (int t = 0; t < 80 && wlog.size() < 20; t++) begin
            drive();
            cycle();
        end
        check("cap_writes", wlog.size(), 20);
        if (wlog.size() >= 20) begin
            sizes.delete();
            cur = 1;
            for (int k = 0; k < 20; k++) begin
                check("cap_data", wlog[k].d, 16'h0100 + DW'(k));
                if (k > 0) begin
                    if (wlog[k].cyc - wlog[k-1].cyc == 1) cur++;
                    else begin
                        sizes.push_back(cur);
                        cur = 1;
                    end
                end
            end
            sizes.push_back(cur);
            check("cap_nbursts", sizes.size(), 3);
            if (sizes.size() == 3) begin
                check("cap_burst0", sizes[0], 8);
                check("cap_burst1", sizes[1], 8);
                check("cap_burst2", sizes[2], 4);
            end
        end

        // FIFO full for 5 cycles after beat 3 of 6
        do_reset();
        push_pkt(0, 6, 16'h0400, 1'b1);
        fullc = 0;
        for (int t = 0; t < 60 && wlog.size() < 6; t++) begin
            fifo_full = (wlog.size() == 3) && (fullc < 5);
            if (fifo_full) fullc++;
            drive();
            cycle();
        end
        fifo_full = 1'b0;
        check("full_writes", wlog.size(), 6);
        if (wlog.size() >= 6) begin
            for (int k = 0; k < 6; k++)
                check("full_data", wlog[k].d, 16'h0400 + DW'(k));
            check("full_stall", wlog[3].cyc - wlog[2].cyc, 6);
            check("full_resume", wlog[5].cyc - wlog[3].cyc, 2);
        end

        // Owner 2 drops valid mid-packet while 3 waits
        do_reset();
        push_pkt(2, 5, 16'h0200, 1'b1);
        push_pkt(3, 1, 16'h0300, 1'b1);
        gapc = 0;
        for (int t = 0; t < 60 && wlog.size() < 6; t++) begin
            mute[2] = (wlog.size() == 2) && (gapc < 3);
            if (mute[2]) gapc++;
            drive();
            cycle();
        end
        mute = '0;
        check("gap_writes", wlog.size(), 6);
        if (wlog.size() >= 6) begin
            for (int k = 0; k < 6; k++)
                check("gap_order", wlog[k].req, (k < 5) ? 2 : 3);
            check("gap_hold", wlog[2].cyc - wlog[1].cyc, 4);
        end

        // Random sources and random backpressure
        do_reset();
        vprob = 60;
        total = 0;
        for (int i = 0; i < N; i++) begin
            int seq;
            seq = 0;
            exp_q[i].delete();
            for (int p = 0; p < 6; p++) begin
                int len;
                len = int'($urandom_range(12, 1));
                push_pkt(i, len, {4'(i), 12'(seq)}, 1'b1);
                for (int b = 0; b < len; b++)
                    exp_q[i].push_back({4'(i), 12'(seq + b)});
                seq += len;
                total += len;
            end
        end
        for (int t = 0; t < 4000 && wlog.size() < total; t++) begin
            fifo_full = ($urandom_range(3) == 0);
            drive();
            cycle();
        end
        fifo_full = 1'b0;
        check("rnd_writes", wlog.size(), total);
        for (int i = 0; i < N; i++) begin
            int n;
            int bad;
            n   = 0;
            bad = 0;
            foreach (wlog[k]) begin
                if (wlog[k].req == i) begin
                    if (n >= exp_q[i].size() || wlog[k].d !== exp_q[i][n]) bad++;
                    n++;
                end
            end
            check("rnd_count", n, exp_q[i].size());
            check("rnd_order", bad, 0);
        end
        viol = 0;
        own  = -1;
        bcnt = 0;
        foreach (wlog[k]) begin
            if (own >= 0 && wlog[k].req != own) viol++;
            bcnt++;
            if (wlog[k].l || bcnt == MB) begin
                own  = -1;
                bcnt = 0;
            end else begin
                own = wlog[k].req;
            end
        end
        check("rnd_interleave", viol, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
